sdiv2c: RTL and testbench
=========================

SDIV2C -- requirements
Module: sdiv2C

Interface
REQ-001 The block SHALL use one clock and synchronous, active-low reset.
- CLK  in  1  clock; all state changes on the rising edge.
- RSTn  in  1  reset, synchronous, active-low.
REQ-002 St  in  1  start request; sampled only in IDLE.
REQ-003 Dividend  in  8  signed two's-complement dividend.
REQ-004 Divisor  in  4  signed two's-complement divisor.
REQ-005 Quotient  out  4  signed two's-complement quotient; registered.
REQ-006 Remainder  out  4  signed two's-complement remainder; registered; sign of the dividend.
REQ-007 V  out  1  overflow or divide-by-zero flag; registered.
REQ-008 Done  out  1  result-valid strobe; decoded from State==DONE.

Function
REQ-009 The FSM SHALL have four states: IDLE, DIV, FIX and DONE. DIV carries a 3-bit iteration counter.
REQ-010 In IDLE with St=1, the rising edge SHALL:
- latch sign bits Dividend[7] and Divisor[3];
- latch the magnitudes |Dividend| (8-bit unsigned, -128 gives 128) and |Divisor| (4-bit unsigned, -8 gives 8);
- clear the partial remainder and counter;
- clear V;
- go to DIV.
REQ-011 If Divisor==0 at that edge, the FSM SHALL instead go directly to DONE with V=1, Quotient=0 and Remainder=0.
REQ-012 Each DIV edge SHALL perform one unsigned restoring step:
- shift the 5-bit partial remainder left and shift in the next dividend-magnitude bit, MSB first;
- subtract |Divisor|;
- if the result is non-negative, keep the difference and shift in quotient bit 1;
- otherwise restore and shift in quotient bit 0.
REQ-013 DIV SHALL last exactly 8 edges, counter 0..7. The counter wraps at 7 and the FSM then goes to FIX. The result is an 8-bit magnitude quotient and a 4-bit magnitude remainder.
REQ-014 The FIX edge SHALL apply the overflow rule:
- if signs are equal and the magnitude quotient is greater than 7, set V=1, Quotient=0, Remainder=0;
- if signs differ and the magnitude quotient is greater than 8, do the same.
REQ-015 Otherwise the FIX edge SHALL write the results:
- Quotient = magnitude quotient, two's-complemented if signs differ;
- Remainder = magnitude remainder, two's-complemented if the dividend is negative;
- V=0;
- go to DONE.
REQ-016 DONE SHALL last exactly one cycle with Done=1, then go to IDLE unconditionally.
REQ-017 Latency: the St-sampling edge is edge 0. State is DONE and Done=1 for the cycle after edge 9 (divide-by-zero: after edge 0).
REQ-018 St SHALL be ignored outside IDLE. A new operation can start on the first edge back in IDLE, with no back-to-back start from DONE.
REQ-019 Quotient, Remainder and V SHALL hold their last values until the next FIX or divide-by-zero edge.
- V is also cleared at the start of each operation.
- Operand inputs may change freely after edge 0 without affecting the result.
REQ-020 A magnitude remainder is always less than 8, so Remainder never overflows.

Reset
REQ-021 With RSTn=0 at a rising edge, the block SHALL force: State=IDLE, counter=0, Quotient=0, Remainder=0, V=0, Done=0.
REQ-022 Reset SHALL take priority over St and over any in-progress operation; a reset mid-DIV or mid-FIX aborts it without writing results.
REQ-023 The first St after RSTn returns high SHALL start a fresh operation.

Verification
REQ-024 45 / 7 (0x2D, 0x7) -> Quotient=0110 (6), Remainder=0011 (3), V=0; Done high only in the cycle after edge 9.
REQ-025 Sign combinations:
- -45 / 7 -> Quotient=1010 (-6), Remainder=1101 (-3);
- 45 / -7 -> Quotient=1010 (-6), Remainder=0011 (3);
- -45 / -7 -> Quotient=0110 (6), Remainder=1101 (-3);
- V=0 in all cases.
REQ-026 Range boundaries:
- -64 / 8 -> Quotient=1000 (-8), Remainder=0, V=0;
- 64 / 8 -> V=1, Quotient=0;
- -128 / -8 -> V=1;
- 127 / 1 -> V=1.
REQ-027 Divide by zero: any Dividend / 0 -> V=1, Quotient=0, Remainder=0; Done high in the cycle after edge 0, IDLE one cycle later.
REQ-028 RSTn=0 during DIV (edge 4) with St held high throughout -> all outputs 0, State IDLE, no Done pulse. After RSTn=1, 45 / 7 completes correctly.
REQ-029 St held high continuously -> operations run back to back with a period of 11 cycles. Each operation uses the operands present at its own start edge.

Source files
------------

// File: rtl/sdiv2c_if.sv
// -----------------------------------------------------------------------------
// sdiv2c_if -- start / operand / result bundle for the sdiv2c signed divider.
//
// Handshake: St is a level start request. The divider accepts it only on a
// rising edge where it is in IDLE, and it captures Dividend/Divisor on that
// same edge. St is ignored in every other state. Done is a one-cycle strobe
// that marks Quotient/Remainder/V as valid. Those results then hold until the
// next operation writes them.
//
// Signals
//   St        master->slave  start request
//   Dividend  master->slave  8-bit signed dividend
//   Divisor   master->slave  4-bit signed divisor
//   Quotient  slave->master  4-bit signed quotient (registered)
//   Remainder slave->master  4-bit signed remainder, sign of dividend (registered)
//   V         slave->master  overflow / divide-by-zero flag (registered)
//   Done      slave->master  result-valid strobe
// -----------------------------------------------------------------------------
interface sdiv2c_if;
  logic       St;
  logic [7:0] Dividend;
  logic [3:0] Divisor;
  logic [3:0] Quotient;
  logic [3:0] Remainder;
  logic       V;
  logic       Done;

  modport master (
    output St, Dividend, Divisor,
    input  Quotient, Remainder, V, Done
  );

  modport slave (
    input  St, Dividend, Divisor,
    output Quotient, Remainder, V, Done
  );
endinterface

// File: rtl/sdiv2c.sv
// -----------------------------------------------------------------------------
// sdiv2c -- 8-bit by 4-bit signed divider.
//
// The divider works on sign/magnitude. It captures the operand signs and
// magnitudes, then runs eight unsigned restoring steps. A final fix-up cycle
// checks that the quotient fits in 4 bits and restores the signs.
//
// Sequence: IDLE -> DIV (8 edges) -> FIX -> DONE -> IDLE.
// A zero divisor goes from IDLE straight to DONE.
//
// Ports
//   CLK          clock; all state changes on the rising edge
//   RSTn         synchronous, active-low reset
//   bus          sdiv2c_if.slave (St, Dividend, Divisor in; Quotient,
//                Remainder, V, Done out)
//   o_dbg_state  current FSM state (0 IDLE, 1 DIV, 2 FIX, 3 DONE)
//   o_dbg_cnt    DIV iteration counter
// -----------------------------------------------------------------------------
module sdiv2c (
  input  logic       CLK,
  input  logic       RSTn,
  sdiv2c_if.slave    bus,
  output logic [1:0] o_dbg_state,
  output logic [2:0] o_dbg_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_sgn_a;   // dividend sign
  logic       r_sgn_b;   // divisor sign
  logic [7:0] r_dvd;     // dividend magnitude, consumed MSB first
  logic [3:0] r_mag_b;   // divisor magnitude, 1..8
  logic [4:0] r_rem;     // partial remainder
  logic [7:0] r_quo;     // magnitude quotient, built LSB in
  logic [3:0] r_q;
  logic [3:0] r_r;
  logic       r_v;

  logic [7:0] w_abs_a;
  logic [3:0] w_abs_b;
  logic [5:0] w_shift;
  logic       w_ge;
  logic [4:0] w_diff;
  logic       w_ovf;
  logic [3:0] w_q_fix;
  logic [3:0] w_r_fix;

  // Magnitudes. The most negative values map to 128 and 8. Those results are
  // still correct when read as unsigned.
  assign w_abs_a = bus.Dividend[7] ? (8'd0 - bus.Dividend) : bus.Dividend;
  assign w_abs_b = bus.Divisor[3]  ? (4'd0 - bus.Divisor)  : bus.Divisor;

  // Restoring step. The partial remainder is always below the divisor
  // magnitude (at most 7), so the shifted value fits in 5 bits. The compare
  // uses the full width, so the top bit is harmless.
  assign w_shift = {r_rem, r_dvd[7]};
  assign w_ge    = (w_shift >= {2'b00, r_mag_b});
  assign w_diff  = w_shift[4:0] - {1'b0, r_mag_b};

  // A negative quotient can reach -8. A positive quotient stops at +7.
  assign w_ovf = (r_sgn_a == r_sgn_b) ? (r_quo > 8'd7) : (r_quo > 8'd8);

  assign w_q_fix = (r_sgn_a ^ r_sgn_b) ? (4'd0 - r_quo[3:0]) : r_quo[3:0];
  assign w_r_fix = r_sgn_a ? (4'd0 - r_rem[3:0]) : r_rem[3:0];

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_sgn_a <= 1'b0;
      r_sgn_b <= 1'b0;
      r_dvd   <= 8'd0;
      r_mag_b <= 4'd0;
      r_rem   <= 5'd0;
      r_quo   <= 8'd0;
      r_q     <= 4'd0;
      r_r     <= 4'd0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.St) begin
            r_sgn_a <= bus.Dividend[7];
            r_sgn_b <= bus.Divisor[3];
            r_dvd   <= w_abs_a;
            r_mag_b <= w_abs_b;
            r_rem   <= 5'd0;
            r_quo   <= 8'd0;
            r_cnt   <= 3'd0;
            r_v     <= 1'b0;
            if (bus.Divisor == 4'd0) begin
              // A zero divisor skips the iteration and reports at once.
              r_v     <= 1'b1;
              r_q     <= 4'd0;
              r_r     <= 4'd0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DIV;
            end
          end
        end

        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_shift[4:0];
          r_quo <= {r_quo[6:0], w_ge};
          r_dvd <= {r_dvd[6:0], 1'b0};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= S_FIX;
        end

        S_FIX: begin
          if (w_ovf) begin
            r_v <= 1'b1;
            r_q <= 4'd0;
            r_r <= 4'd0;
          end else begin
            r_v <= 1'b0;
            r_q <= w_q_fix;
            r_r <= w_r_fix;
          end
          r_state <= S_DONE;
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Quotient  = r_q;
  assign bus.Remainder = r_r;
  assign bus.V         = r_v;
  assign bus.Done      = (r_state == S_DONE);

  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_sdiv2c.sv
// -----------------------------------------------------------------------------
// tb_sdiv2c -- self-checking bench for sdiv2c: directed vector table,
// multi-cycle corner sequences, and randomized operands against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_sdiv2c;

  localparam int CLK_PERIOD = 10;

  logic       clk;
  logic       rstn;
  logic [1:0] dbg_state;
  logic [2:0] dbg_cnt;

  sdiv2c_if bus();

  sdiv2c dut (
    .CLK         (clk),
    .RSTn        (rstn),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_cnt   (dbg_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_chk;
  int n_fail;
  logic [8:0] exp_q[$];   // {V, Quotient, Remainder}
  logic [3:0] prev_q;
  logic [3:0] prev_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain signed arithmetic with the 4-bit range rule.
  function automatic logic [8:0] model(input logic [7:0] dvd, input logic [3:0] dvs);
    int a, b, qm, rm;
    logic [3:0] q, r;
    a = int'($signed(dvd));
    b = int'($signed(dvs));
    if (b == 0) return 9'h100;
    qm = (a < 0 ? -a : a) / (b < 0 ? -b : b);
    rm = (a < 0 ? -a : a) % (b < 0 ? -b : b);
    if (((a < 0) == (b < 0)) ? (qm > 7) : (qm > 8)) return 9'h100;
    q = ((a < 0) != (b < 0)) ? 4'(-qm) : 4'(qm);
    r = (a < 0) ? 4'(-rm) : 4'(rm);
    return {1'b0, q, r};
  endfunction

  // ---------------- driver ----------------
  // Called just after an edge with the DUT in IDLE. Starts an operation,
  // scrambles the operands after the start edge, and waits for Done.
  task automatic do_op(input logic [7:0] dvd, input logic [3:0] dvs, input bit hold,
                       output logic [3:0] q, output logic [3:0] r, output logic v,
                       output int lat, output time t0);
    bus.St       = 1'b1;
    bus.Dividend = dvd;
    bus.Divisor  = dvs;
    @(posedge clk);
    t0 = $time;
    #1;
    if (!hold) bus.St = 1'b0;
    bus.Dividend = 8'($urandom);
    bus.Divisor  = 4'($urandom);
    lat = 0;
    while (bus.Done !== 1'b1 && lat < 20) begin
      if (lat == 3) begin
        chk("hold_quotient", bus.Quotient, prev_q);
        chk("hold_remainder", bus.Remainder, prev_r);
        chk("v_cleared_at_start", bus.V, 0);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    q = bus.Quotient;
    r = bus.Remainder;
    v = bus.V;
    @(posedge clk);
    #1;
    chk("done_one_cycle", bus.Done, 0);
    chk("back_to_idle", dbg_state, 0);
  endtask

  task automatic run_check(input logic [7:0] dvd, input logic [3:0] dvs, input bit hold,
                           output time t0);
    logic [3:0] q, r;
    logic       v;
    int         lat;
    logic [8:0] e;
    do_op(dvd, dvs, hold, q, r, v, lat, t0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("V", v, e[8]);
      chk("Quotient", q, e[7:4]);
      chk("Remainder", r, e[3:0]);
      chk("latency", lat, (dvs == 4'd0) ? 0 : 9);
      prev_q = e[7:4];
      prev_r = e[3:0];
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       v;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  initial begin
    time t0, t1, t2;
    logic [7:0] rd;
    logic [3:0] rs;
    bit hold;

    n_chk = 0;
    n_fail = 0;
    prev_q = 4'd0;
    prev_r = 4'd0;

    // A 4-bit divisor pattern of 1000 is -8, so the divisor-8 boundary
    // cases become 64 / -8 (fits as -8) and -64 / -8 (+8 overflows).
    tbl[0]  = '{8'h2D, 4'h7, 4'h6, 4'h3, 1'b0};  //  45 /  7
    tbl[1]  = '{8'hD3, 4'h7, 4'hA, 4'hD, 1'b0};  // -45 /  7
    tbl[2]  = '{8'h2D, 4'h9, 4'hA, 4'h3, 1'b0};  //  45 / -7
    tbl[3]  = '{8'hD3, 4'h9, 4'h6, 4'hD, 1'b0};  // -45 / -7
    tbl[4]  = '{8'h40, 4'h8, 4'h8, 4'h0, 1'b0};  //  64 / -8 -> -8
    tbl[5]  = '{8'hC0, 4'h8, 4'h0, 4'h0, 1'b1};  // -64 / -8 -> +8 overflow
    tbl[6]  = '{8'h80, 4'h8, 4'h0, 4'h0, 1'b1};  // -128 / -8
    tbl[7]  = '{8'h7F, 4'h1, 4'h0, 4'h0, 1'b1};  // 127 / 1
    tbl[8]  = '{8'h2D, 4'h0, 4'h0, 4'h0, 1'b1};  // divide by zero
    tbl[9]  = '{8'h80, 4'h0, 4'h0, 4'h0, 1'b1};  // divide by zero
    tbl[10] = '{8'h00, 4'h5, 4'h0, 4'h0, 1'b0};  //   0 /  5
    tbl[11] = '{8'hF8, 4'hF, 4'h0, 4'h0, 1'b1};  //  -8 / -1 -> +8 overflow
    tbl[12] = '{8'h07, 4'hF, 4'h9, 4'h0, 1'b0};  //   7 / -1 -> -7

    rstn = 1'b0;
    bus.St = 1'b0;
    bus.Dividend = 8'h00;
    bus.Divisor = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", dbg_state, 0);
    chk("reset_cnt", dbg_cnt, 0);
    chk("reset_quotient", bus.Quotient, 0);
    chk("reset_remainder", bus.Remainder, 0);
    chk("reset_v", bus.V, 0);
    chk("reset_done", bus.Done, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      exp_q.push_back({tbl[i].v, tbl[i].q, tbl[i].r});
      run_check(tbl[i].dvd, tbl[i].dvs, 1'b0, t0);
    end

    // Reset on DIV edge 4 with St held high: the operation is aborted.
    bus.St = 1'b1;
    bus.Dividend = 8'h2D;
    bus.Divisor = 4'h7;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_div_state", dbg_state, 1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_state", dbg_state, 0);
    chk("abort_cnt", dbg_cnt, 0);
    chk("abort_quotient", bus.Quotient, 0);
    chk("abort_remainder", bus.Remainder, 0);
    chk("abort_v", bus.V, 0);
    chk("abort_done", bus.Done, 0);
    @(posedge clk);
    #1;
    chk("abort_done_held", bus.Done, 0);
    chk("abort_state_held", dbg_state, 0);
    rstn = 1'b1;
    prev_q = 4'd0;
    prev_r = 4'd0;
    exp_q.push_back({1'b0, 4'h6, 4'h3});
    run_check(8'h2D, 4'h7, 1'b1, t0);

    // St held continuously: starts every 11 cycles with their own operands.
    exp_q.push_back(model(8'h64, 4'h3));
    run_check(8'h64, 4'h3, 1'b1, t1);
    exp_q.push_back(model(8'h9C, 4'h5));
    run_check(8'h9C, 4'h5, 1'b1, t2);
    chk("b2b_period", int'((t1 - t0) / CLK_PERIOD), 11);
    chk("b2b_period2", int'((t2 - t1) / CLK_PERIOD), 11);
    bus.St = 1'b0;
    @(posedge clk);
    #1;

    // Randomized operands against the model.
    for (int n = 0; n < 60; n++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      hold = ($urandom_range(0, 3) == 0);
      exp_q.push_back(model(rd, rs));
      run_check(rd, rs, hold, t0);
    end
    bus.St = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
